// File: rtl/beh_stack_shifter.sv
// LIFO stack built as a bidirectional shift register; stk_q[0] is the top of stack.
// Define STACK_ERR_EN to add the sticky overflow/underflow outputs ovf and unf.
module beh_stack_shifter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
`ifdef STACK_ERR_EN
  ,
  output logic             ovf,
  output logic             unf
`endif
);

  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [WIDTH-1:0] stk_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_w, full_w;
  logic             do_push, do_pop, do_repl;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_W'(DEPTH));

  // Push+pop on an empty stack degenerates to a plain push.
  assign do_push = push && (!pop || empty_w) && !full_w;
  assign do_pop  = pop && !push && !empty_w;
  assign do_repl = push && pop && !empty_w;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) stk_d[i] = stk_q[i];
    count_d = count_q;
    if (do_push) begin
      for (int i = 1; i < DEPTH; i++) stk_d[i] = stk_q[i-1];
      stk_d[0] = din;
      count_d  = count_q + CNT_W'(1);
    end else if (do_pop) begin
      for (int i = 0; i < DEPTH-1; i++) stk_d[i] = stk_q[i+1];
      stk_d[DEPTH-1] = '0;
      count_d        = count_q - CNT_W'(1);
    end else if (do_repl) begin
      stk_d[0] = din;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stk_q[gi] <= '0;
        else     stk_q[gi] <= stk_d[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

`ifdef STACK_ERR_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push && !pop && full_w) ovf_q <= 1'b1;
      if (pop && empty_w)         unf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`endif

  assign dout  = stk_q[0];
  assign count = count_q;
  assign empty = empty_w;
  assign full  = full_w;
  assign valid = !empty_w;

endmodule

// File: tb/tb_beh_stack_shifter.sv
// Scoreboard bench for beh_stack_shifter: a queue-based reference stack predicts each
// cycle's outputs, a monitor compares them one cycle-line at a time.
module tb_beh_stack_shifter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             valid, empty, full;
  logic [CNT_W-1:0] count;
  logic             ovf_w, unf_w;

`ifdef STACK_ERR_EN
  beh_stack_shifter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .dout(dout), .valid(valid), .empty(empty), .full(full), .count(count),
    .ovf(ovf_w), .unf(unf_w)
  );
`else
  beh_stack_shifter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .dout(dout), .valid(valid), .empty(empty), .full(full), .count(count)
  );
  assign ovf_w = 1'b0;
  assign unf_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int     dout;
    int     count;
    bit     empty;
    bit     full;
    bit     ovf;
    bit     unf;
    string  tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference model: model_stk[0] is the top word.
  int model_stk[$];
  bit model_ovf = 1'b0;
  bit model_unf = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic exp_t model_snapshot(input string tag);
    exp_t e;
    e.dout  = (model_stk.size() > 0) ? model_stk[0] : 0;
    e.count = model_stk.size();
    e.empty = (model_stk.size() == 0);
    e.full  = (model_stk.size() == DEPTH);
    e.ovf   = model_ovf;
    e.unf   = model_unf;
    e.tag   = tag;
    return e;
  endfunction

  task automatic compare_outputs(input exp_t e);
    check({e.tag, ".dout"},  int'(dout),  e.dout);
    check({e.tag, ".count"}, int'(count), e.count);
    check({e.tag, ".empty"}, int'(empty), int'(e.empty));
    check({e.tag, ".full"},  int'(full),  int'(e.full));
    check({e.tag, ".valid"}, int'(valid), int'(!e.empty));
`ifdef STACK_ERR_EN
    check({e.tag, ".ovf"},   int'(ovf_w), int'(e.ovf));
    check({e.tag, ".unf"},   int'(unf_w), int'(e.unf));
`endif
  endtask

  // One stack operation: update the model, queue the prediction, apply at the next edge.
  task automatic step(input bit p, input bit q, input int d, input string tag);
    int sz;
    @(negedge clk);
    push = p;
    pop  = q;
    din  = WIDTH'(d);
    sz = model_stk.size();
    if (p && q) begin
      if (sz == 0) begin
        model_stk.push_front(d);
        model_unf = 1'b1;
      end else begin
        model_stk[0] = d;
      end
    end else if (p) begin
      if (sz == DEPTH) model_ovf = 1'b1;
      else             model_stk.push_front(d);
    end else if (q) begin
      if (sz == 0) model_unf = 1'b1;
      else         void'(model_stk.pop_front());
    end
    exp_q.push_back(model_snapshot(tag));
    @(posedge clk);
  endtask

  // Asynchronous reset pulse placed between edges, checked immediately.
  task automatic async_reset(input string tag);
    #3;
    push = 1'b0;
    pop  = 1'b0;
    rst  = 1'b1;
    model_stk.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
    #1;
    compare_outputs(model_snapshot(tag));
    $display("txn %0d %s: count=%0d dout=0x%0h empty=%0b", txn, tag, count, dout, empty);
    txn++;
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      compare_outputs(e);
      $display("txn %0d %s: push=%0b pop=%0b din=0x%0h -> dout=0x%0h count=%0d", txn, e.tag,
               push, pop, din, dout, count);
      txn++;
    end
  end

  initial begin
    int wait_cycles;
    // Power-on reset state
    #2;
    compare_outputs(model_snapshot("reset"));
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a stream
    step(1, 0, 8'h11, "push11");
    step(1, 0, 8'h22, "push22");
    async_reset("midrst");
    step(1, 0, 8'h33, "push33");
    step(0, 1, 0, "pop33");

    // Fill, overflow, reverse drain, underflow
    step(1, 0, 8'hA1, "fillA1");
    step(1, 0, 8'hA2, "fillA2");
    step(1, 0, 8'hA3, "fillA3");
    step(1, 0, 8'hA4, "fillA4");
    step(1, 0, 8'hFF, "ovf");
    step(0, 0, 0, "hold");
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, "drain");
    step(0, 1, 0, "unf");

    // Simultaneous push+pop: mid-depth, full, empty
    step(1, 0, 8'h11, "push11");
    step(1, 0, 8'h22, "push22");
    step(1, 1, 8'h5C, "repl2");
    step(1, 0, 8'h33, "push33");
    step(1, 0, 8'h44, "push44");
    step(1, 1, 8'h9D, "replfull");
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, "drain2");
    step(1, 1, 8'h77, "pp_empty");
    step(0, 1, 0, "pop77");

    // Randomised traffic against the reference stack
    async_reset("rst_rand");
    for (int i = 0; i < 1000; i++) begin
      bit p, q;
      p = ($urandom_range(0, 99) < 55);
      q = ($urandom_range(0, 99) < 45);
      step(p, q, int'($urandom_range(0, 255)), "rand");
    end
    step(0, 0, 0, "tail");

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_scoreboard: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
